// File: rtl/spi_flash_seq.sv
// SPI flash command sequencer: turns CPU READ/WRITE/ERASE/READ_STATUS requests
// into SPI-master command frames, polling the status register after WRITE/ERASE.
module spi_flash_seq #(
  parameter int          ACK_TIMEOUT = 16,
  parameter logic [15:0] POLL_MAX    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [23:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [7:0]  m_command,
  output logic [23:0] m_address,
  output logic [31:0] m_data_in,
  output logic [2:0]  m_commtype,
  output logic        m_validflag,
  input  logic        m_tready,
  input  logic [31:0] m_data_out,
  input  logic        m_validflag_out
);

  // Handshake: a request transfers on a clk edge where req_valid and req_ready
  // are both 1; rsp_valid is a single-cycle pulse and is never back-pressured.
  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_ACK, WAIT_DONE, WAIT_DATA, RESP
  } state_t;

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RSTAT = 2'b11;

  localparam int              ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [1:0]        step, step_nxt;
  logic [ACK_W-1:0]  ack_cnt;
  logic [15:0]       poll_cnt;
  logic [15:0]       poll_cnt_inc;
  logic [1:0]        op_q;
  logic [23:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       data_q;
  logic              err_q;

  logic              accept, load_cmd, ack_clr, ack_inc, poll_inc, capture, err_set;
  logic [1:0]        sel_op;
  logic [23:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [7:0]        cmd_nxt;
  logic [2:0]        ctype_nxt;
  logic [23:0]       addr_nxt;
  logic [31:0]       data_nxt;

  logic              single_step, is_last, is_poll, data_step;

  assign single_step  = (op_q == OP_READ) || (op_q == OP_RSTAT);
  assign is_last      = single_step || (step == 2'd2);
  assign is_poll      = !single_step && (step == 2'd2);
  assign data_step    = (m_commtype == 3'b001) || (m_commtype == 3'b010);
  assign poll_cnt_inc = poll_cnt + 16'd1;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    accept    = 1'b0;
    load_cmd  = 1'b0;
    ack_clr   = 1'b0;
    ack_inc   = 1'b0;
    poll_inc  = 1'b0;
    capture   = 1'b0;
    err_set   = 1'b0;
    sel_op    = op_q;
    sel_addr  = addr_q;
    sel_wdata = wdata_q;
    case (state)
      IDLE: begin
        if (req_valid) begin
          accept    = 1'b1;
          load_cmd  = 1'b1;
          step_nxt  = 2'd0;
          sel_op    = req_op;
          sel_addr  = req_addr;
          sel_wdata = req_wdata;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (m_tready) begin
          ack_clr   = 1'b1;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (!m_tready) begin
          state_nxt = data_step ? WAIT_DATA : WAIT_DONE;
        end else if (ack_cnt == ACK_LAST) begin
          err_set   = 1'b1;
          state_nxt = RESP;
        end else begin
          ack_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (m_tready) begin
          if (is_last) begin
            state_nxt = RESP;
          end else begin
            step_nxt  = step + 2'd1;
            load_cmd  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      WAIT_DATA: begin
        if (m_validflag_out) begin
          capture = 1'b1;
          if (is_poll) begin
            poll_inc = 1'b1;
            // Flash still busy: re-issue the same poll unless the budget is spent.
            if (m_data_out[24]) begin
              if (poll_cnt_inc == POLL_MAX) begin
                err_set   = 1'b1;
                state_nxt = RESP;
              end else begin
                state_nxt = ISSUE;
              end
            end else begin
              state_nxt = RESP;
            end
          end else if (is_last) begin
            state_nxt = RESP;
          end else begin
            step_nxt  = step + 2'd1;
            load_cmd  = 1'b1;
            state_nxt = ISSUE;
          end
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command table indexed by operation and the step about to be issued.
  always_comb begin
    cmd_nxt   = 8'h00;
    ctype_nxt = 3'b000;
    addr_nxt  = 24'h0;
    data_nxt  = 32'h0;
    case (sel_op)
      OP_READ: begin
        cmd_nxt   = 8'h03;
        ctype_nxt = 3'b010;
        addr_nxt  = sel_addr;
      end
      OP_RSTAT: begin
        cmd_nxt   = 8'h05;
        ctype_nxt = 3'b001;
      end
      default: begin
        case (step_nxt)
          2'd0: begin
            cmd_nxt   = 8'h06;
            ctype_nxt = 3'b000;
          end
          2'd1: begin
            addr_nxt = sel_addr;
            if (sel_op == OP_WRITE) begin
              cmd_nxt   = 8'h02;
              ctype_nxt = 3'b100;
              data_nxt  = sel_wdata;
            end else begin
              cmd_nxt   = 8'h20;
              ctype_nxt = 3'b101;
            end
          end
          default: begin
            cmd_nxt   = 8'h05;
            ctype_nxt = 3'b001;
          end
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      step       <= 2'd0;
      ack_cnt    <= '0;
      poll_cnt   <= 16'h0;
      op_q       <= 2'b00;
      addr_q     <= 24'h0;
      wdata_q    <= 32'h0;
      data_q     <= 32'h0;
      err_q      <= 1'b0;
      m_command  <= 8'h00;
      m_address  <= 24'h0;
      m_data_in  <= 32'h0;
      m_commtype <= 3'b000;
    end else begin
      state <= state_nxt;
      step  <= step_nxt;
      if (accept) begin
        op_q     <= req_op;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        poll_cnt <= 16'h0;
        data_q   <= 32'h0;
        err_q    <= 1'b0;
      end
      if (load_cmd) begin
        m_command  <= cmd_nxt;
        m_address  <= addr_nxt;
        m_data_in  <= data_nxt;
        m_commtype <= ctype_nxt;
      end
      if (ack_clr) begin
        ack_cnt <= '0;
      end else if (ack_inc) begin
        ack_cnt <= ack_cnt + 1'b1;
      end
      if (poll_inc) poll_cnt <= poll_cnt_inc;
      if (capture)  data_q   <= m_data_out;
      if (err_set)  err_q    <= 1'b1;
    end
  end

  // Strobes are gated by rst so an abort never leaks a pulse in the reset cycle.
  assign req_ready   = (state == IDLE);
  assign m_validflag = rst && (state == ISSUE) && m_tready;
  assign rsp_valid   = rst && (state == RESP);
  assign rsp_err     = rsp_valid && err_q;
  assign rsp_rdata   = (rsp_valid && single_step) ? data_q : 32'h0;

endmodule

// File: tb/tb_spi_flash_seq.sv
// Randomized scoreboard bench for spi_flash_seq with a behavioural SPI-master
// model and a transaction-level reference of the command sequences.
module tb_spi_flash_seq;

  localparam int          ACK_TO = 10;
  localparam logic [15:0] PMAX   = 16'd3;
  localparam logic [1:0]  OP_READ = 2'b00, OP_WRITE = 2'b01, OP_ERASE = 2'b10, OP_RSTAT = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  m_command;
  logic [23:0] m_address;
  logic [31:0] m_data_in;
  logic [2:0]  m_commtype;
  logic        m_validflag, m_tready, m_validflag_out;
  logic [31:0] m_data_out;

  spi_flash_seq #(.ACK_TIMEOUT(ACK_TO), .POLL_MAX(PMAX)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_command(m_command), .m_address(m_address), .m_data_in(m_data_in),
    .m_commtype(m_commtype), .m_validflag(m_validflag), .m_tready(m_tready),
    .m_data_out(m_data_out), .m_validflag_out(m_validflag_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  // issue entry: {chk_addr, chk_data, cmd[7:0], commtype[2:0], addr[23:0], data[31:0]}
  logic [68:0] exp_iss_q[$];
  logic [32:0] exp_rsp_q[$];
  int checks = 0;
  int failures = 0;
  int iss_cnt = 0, rsp_cnt = 0, last_iss_cyc = 0, last_rsp_cyc = 0;

  // master-model controls
  logic [31:0] rd_word = 32'h0;
  int wip_left = 0;
  bit ack_stuck = 1'b0;
  int stall_cycles = 0;
  int force_busy = 0;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] iss(input bit ca, input bit cd, input logic [7:0] c,
                                      input logic [2:0] t, input logic [23:0] a, input logic [31:0] d);
    return {ca, cd, c, t, a, d};
  endfunction

  // ---------------- reference model ----------------
  task automatic expect_txn(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d,
                            input logic [31:0] w, input int wip_n, input bit stuck);
    int polls;
    if (stuck) begin
      case (op)
        OP_READ:  exp_iss_q.push_back(iss(1, 0, 8'h03, 3'b010, a, 0));
        OP_RSTAT: exp_iss_q.push_back(iss(0, 0, 8'h05, 3'b001, 0, 0));
        default:  exp_iss_q.push_back(iss(0, 0, 8'h06, 3'b000, 0, 0));
      endcase
      exp_rsp_q.push_back({1'b1, 32'h0});
      return;
    end
    case (op)
      OP_READ: begin
        exp_iss_q.push_back(iss(1, 0, 8'h03, 3'b010, a, 0));
        exp_rsp_q.push_back({1'b0, w});
      end
      OP_RSTAT: begin
        exp_iss_q.push_back(iss(0, 0, 8'h05, 3'b001, 0, 0));
        exp_rsp_q.push_back({1'b0, w});
      end
      default: begin
        exp_iss_q.push_back(iss(0, 0, 8'h06, 3'b000, 0, 0));
        if (op == OP_WRITE) exp_iss_q.push_back(iss(1, 1, 8'h02, 3'b100, a, d));
        else                exp_iss_q.push_back(iss(1, 0, 8'h20, 3'b101, a, 0));
        polls = (wip_n >= int'(PMAX)) ? int'(PMAX) : wip_n + 1;
        for (int i = 0; i < polls; i++) exp_iss_q.push_back(iss(0, 0, 8'h05, 3'b001, 0, 0));
        exp_rsp_q.push_back({(wip_n >= int'(PMAX)), 32'h0});
      end
    endcase
  endtask

  // ---------------- SPI master model ----------------
  initial begin
    logic [7:0] c;
    bit dstep;
    int busy;
    m_tready = 1'b1;
    m_validflag_out = 1'b0;
    m_data_out = 32'h0;
    forever begin
      @(negedge clk);
      if (m_validflag && !ack_stuck) begin
        c = m_command;
        dstep = (m_commtype == 3'b001) || (m_commtype == 3'b010);
        busy = (force_busy > 0) ? force_busy : $urandom_range(1, 3);
        @(posedge clk); #1 m_tready = 1'b0;
        for (int i = 0; i < busy; i++) begin
          @(posedge clk); #1;
          m_validflag_out = (i == 0) && !dstep && (busy > 1);
          m_data_out = $urandom;
        end
        if (dstep) begin
          if (c == 8'h05 && wip_left > 0) begin
            m_data_out = $urandom | 32'h0100_0000;
            wip_left--;
          end else begin
            m_data_out = rd_word;
          end
          m_validflag_out = 1'b1;
          @(posedge clk); #1;
          m_validflag_out = 1'b0;
          m_data_out = $urandom;
        end
        m_tready = 1'b1;
      end else if (stall_cycles > 0) begin
        m_tready = 1'b0;
        repeat (stall_cycles) @(posedge clk);
        #1;
        stall_cycles = 0;
        m_tready = 1'b1;
      end
    end
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin : mon_iss
    logic [68:0] e;
    if (m_validflag) begin
      iss_cnt++;
      last_iss_cyc = cyc;
      check("issue_needs_tready", m_tready, 1'b1);
      if (exp_iss_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got cmd %h, expected no issue", m_command);
      end else begin
        e = exp_iss_q.pop_front();
        check("issue_cmd", {m_command, m_commtype}, {e[66:59], e[58:56]});
        if (e[68]) check("issue_addr", m_address, e[55:32]);
        if (e[67]) check("issue_data", m_data_in, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin : mon_rsp
    logic [32:0] e;
    if (rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_rsp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp: got err=%0b rdata=%h, expected no response", rsp_err, rsp_rdata);
      end else begin
        e = exp_rsp_q.pop_front();
        check("rsp_err_rdata", {rsp_err, rsp_rdata}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d);
    int guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL send_ready: got req_ready=0 for 200 cycles, required 1");
    end
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_op    = 2'($urandom_range(0, 3));
    req_addr  = 24'($urandom);
    req_wdata = $urandom;
  endtask

  task automatic wait_done();
    int guard = 0;
    while ((exp_iss_q.size() != 0 || exp_rsp_q.size() != 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout: got %0d issues / %0d responses pending, required 0",
               exp_iss_q.size(), exp_rsp_q.size());
      exp_iss_q.delete();
      exp_rsp_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn(input logic [1:0] op, input logic [23:0] a, input logic [31:0] d,
                         input logic [31:0] w, input int wip_n, input bit stuck, input int stall);
    rd_word      = w;
    wip_left     = (op == OP_WRITE || op == OP_ERASE) ? wip_n : 0;
    ack_stuck    = stuck;
    stall_cycles = stall;
    expect_txn(op, a, d, w, wip_n, stuck);
    send(op, a, d);
    wait_done();
    ack_stuck = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0]  op;
    logic [23:0] a;
    logic [31:0] d, w;
    int wn, st, acc, seen, guard, base_i, base_r;
    bit stuck;

    rst = 1'b0;
    req_valid = 1'b0;
    req_op = 2'b00;
    req_addr = 24'h0;
    req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_m_validflag", m_validflag, 1'b0);
    check("rst_m_fields", {m_command, m_address, m_data_in, m_commtype}, 67'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // READ with one-cycle request-to-issue latency
    rd_word = 32'hDEADBEEF;
    wip_left = 0;
    expect_txn(OP_READ, 24'h000100, 32'h0, 32'hDEADBEEF, 0, 0);
    send(OP_READ, 24'h000100, 32'h0);
    check("issue_latency", m_validflag, 1'b1);
    wait_done();

    // WRITE with two busy polls
    run_txn(OP_WRITE, 24'h000200, 32'h12345678, 32'h0, 2, 0, 0);
    // READ_STATUS returns the raw word, WIP set or not
    run_txn(OP_RSTAT, 24'h0, 32'h0, 32'h0100_00A5, 0, 0, 0);
    // ERASE with WIP stuck: exactly POLL_MAX polls then error
    run_txn(OP_ERASE, 24'h00ABCD, 32'h0, 32'h0, 100, 0, 0);
    // WRITE with WIP clearing on the last allowed poll
    run_txn(OP_WRITE, 24'h123456, 32'hCAFEF00D, 32'h0, int'(PMAX) - 1, 0, 1);

    // master never acknowledges: error exactly ACK_TO cycles after WAIT_ACK entry
    run_txn(OP_READ, 24'h000300, 32'h0, 32'h55AA55AA, 0, 1, 0);
    check("ack_timeout_cycles", last_rsp_cyc - last_iss_cyc, ACK_TO + 1);

    // reset asserted during WAIT_DONE of the program-page step
    force_busy = 8;
    rd_word = 32'h0;
    wip_left = 0;
    expect_txn(OP_WRITE, 24'h000400, 32'hA5A5A5A5, 32'h0, 0, 0);
    send(OP_WRITE, 24'h000400, 32'hA5A5A5A5);
    guard = 0;
    while (!(m_validflag && m_command == 8'h02) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("abort_reached_program", {m_validflag, m_command}, {1'b1, 8'h02});
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_iss_q.delete();
    exp_rsp_q.delete();
    @(negedge clk);
    check("abort_req_ready", req_ready, 1'b1);
    check("abort_rsp_valid", rsp_valid, 1'b0);
    check("abort_m_command", m_command, 8'h00);
    rst = 1'b1;
    base_i = iss_cnt;
    base_r = rsp_cnt;
    repeat (30) @(negedge clk);
    check("abort_no_issue", iss_cnt - base_i, 0);
    check("abort_no_rsp", rsp_cnt - base_r, 0);
    force_busy = 0;

    // req_valid held high: one accept per transaction, re-accept only in IDLE
    rd_word = 32'h0BADC0DE;
    wip_left = 0;
    expect_txn(OP_READ, 24'h000500, 32'h0, 32'h0BADC0DE, 0, 0);
    expect_txn(OP_READ, 24'h000500, 32'h0, 32'h0BADC0DE, 0, 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_op = OP_READ;
    req_addr = 24'h000500;
    acc = 0;
    seen = 0;
    guard = 0;
    while (guard < 300) begin
      if (req_valid && req_ready) acc++;
      if (rsp_valid) seen++;
      if (seen == 2) break;
      @(negedge clk);
      guard++;
    end
    req_valid = 1'b0;
    check("hold_accepts", acc, 2);
    check("hold_responses", seen, 2);
    wait_done();

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      op = 2'($urandom_range(0, 3));
      a = 24'($urandom);
      d = $urandom;
      w = $urandom;
      wn = $urandom_range(0, 4);
      stuck = ($urandom_range(0, 9) == 0);
      st = stuck ? 0 : $urandom_range(0, 2);
      if (op == OP_WRITE || op == OP_ERASE) w[24] = 1'b0;
      run_txn(op, a, d, w, wn, stuck, st);
    end

    repeat (20) @(negedge clk);
    check("queues_drained", exp_iss_q.size() + exp_rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
